// File: rtl/zpu_sd_bridge_pkg.sv
// zpu_sd_bridge shared definitions: FSM states, ZPU strobe bit positions,
// status byte field positions and the default SD acknowledge timeout.
package zpu_sd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER
    } sd_state_t;

    // zpu_out2 control bits
    localparam int OUT2_LBA_SEL = 0;
    localparam int OUT2_BLK_RD  = 1;
    localparam int OUT2_BLK_WR  = 2;

    // zpu_rd / zpu_wr strobe bits
    localparam int RD_DATA = 2;
    localparam int WR_IO   = 5;
    localparam int WR_DATA = 6;

    // zpu_in2 status fields (lsb positions)
    localparam int IN2_IO_DONE  = 0;
    localparam int IN2_MOUNTED  = 1;
    localparam int IN2_FILENO   = 2;
    localparam int IN2_FILETYPE = 5;
    localparam int IN2_READONLY = 7;

    localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd10_000_000;

endpackage

// File: rtl/zpu_sd_bridge_if.sv
// hps_io SD block bus between the bridge (master) and hps_io (slave):
// request/LBA out, acknowledge in, and the sector buffer port A signals.
interface zpu_sd_bridge_if #(
    parameter int BUF_AW = 9
) ();

    logic [31:0]       sd_lba;
    logic              sd_rd;
    logic              sd_wr;
    logic              sd_ack;
    logic [BUF_AW-1:0] sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic [7:0]        sd_buff_din;
    logic              sd_buff_wr;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        output sd_buff_din,
        input  sd_ack,
        input  sd_buff_addr,
        input  sd_buff_dout,
        input  sd_buff_wr
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        input  sd_buff_din,
        output sd_ack,
        output sd_buff_addr,
        output sd_buff_dout,
        output sd_buff_wr
    );

endinterface

// File: rtl/zpu_sd_bridge_dpram.sv
// dpram: true dual-port RAM, registered reads on both ports.
// Ports: clk; port A addr_a/we_a/d_a/q_a; port B addr_b/we_b/d_b/q_b.
module dpram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              we_a,
    input  logic [DATA_W-1:0] d_a,
    output logic [DATA_W-1:0] q_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              we_b,
    input  logic [DATA_W-1:0] d_b,
    output logic [DATA_W-1:0] q_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Port A is the later write so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= d_b;
        if (we_a) mem[addr_a] <= d_a;
        q_a <= mem[addr_a];
        q_b <= mem[addr_b];
    end

endmodule

// File: rtl/zpu_sd_bridge.sv
// zpu_sd_bridge: ZPU register interface to hps_io SD block interface.
// Holds the sector buffer, LBA latch, block request FSM and mount status.
// Ports: clk_sys, reset (sync, active high); zpu_out2/out3/rd/wr in,
// zpu_in2 status / zpu_in3 data out; sd (hps_io bus, master modport);
// img_mounted, img_size, ioctl_index in; sd_timeout out.
// Option: define ZPU_SD_TIMEOUT_EN to abort requests hps_io never
// acknowledges within TIMEOUT_CYC cycles.
module zpu_sd_bridge
    import zpu_sd_pkg::*;
#(
    parameter int BUF_AW = 9
`ifdef ZPU_SD_TIMEOUT_EN
    ,
    parameter logic [23:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [31:0]         zpu_out2,
    input  logic [31:0]         zpu_out3,
    input  logic [15:0]         zpu_rd,
    input  logic [15:0]         zpu_wr,
    output logic [7:0]          zpu_in2,
    output logic [31:0]         zpu_in3,
    zpu_sd_bridge_if.master     sd,
    input  logic                img_mounted,
    input  logic [63:0]         img_size,
    input  logic [7:0]          ioctl_index,
    output logic                sd_timeout
);

    logic lba_sel;
    logic io_wr;
    assign lba_sel = zpu_out2[OUT2_LBA_SEL];
    assign io_wr   = zpu_wr[WR_IO];

    // ---------------- edge detectors ----------------
    logic dwr_d1, dwr_d2, dwr_inc;
    logic drd_q, blk_rd_q, blk_wr_q, ack_q, mnt_q;
    logic dwr_ev, drd_fall, blk_rd_rise, blk_wr_rise;
    logic ack_fall, mnt_rise;

    assign dwr_ev      = dwr_d1 & ~dwr_d2;
    assign drd_fall    = drd_q & ~zpu_rd[RD_DATA];
    assign blk_rd_rise = zpu_out2[OUT2_BLK_RD] & ~blk_rd_q;
    assign blk_wr_rise = zpu_out2[OUT2_BLK_WR] & ~blk_wr_q;
    assign ack_fall    = ack_q & ~sd.sd_ack;
    assign mnt_rise    = img_mounted & ~mnt_q;

    // Level trackers load the live input during reset so a level that
    // is already high when reset releases is not seen as a new edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dwr_d1   <= 1'b0;
            dwr_d2   <= 1'b0;
            dwr_inc  <= 1'b0;
            drd_q    <= zpu_rd[RD_DATA];
            blk_rd_q <= zpu_out2[OUT2_BLK_RD];
            blk_wr_q <= zpu_out2[OUT2_BLK_WR];
            ack_q    <= sd.sd_ack;
            mnt_q    <= img_mounted;
        end else begin
            dwr_d1   <= zpu_wr[WR_DATA];
            dwr_d2   <= dwr_d1;
            dwr_inc  <= dwr_ev & ~lba_sel;
            drd_q    <= zpu_rd[RD_DATA];
            blk_rd_q <= zpu_out2[OUT2_BLK_RD];
            blk_wr_q <= zpu_out2[OUT2_BLK_WR];
            ack_q    <= sd.sd_ack;
            mnt_q    <= img_mounted;
        end
    end

    // ---------------- ZPU buffer pointer / LBA ----------------
    logic [BUF_AW-1:0] addr;
    logic [31:0]       lba_q;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            addr <= '0;
        end else if (io_wr) begin
            addr <= '0;
        end else if (dwr_inc | drd_fall) begin
            addr <= addr + BUF_AW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            lba_q <= '0;
        end else if (dwr_ev & lba_sel) begin
            lba_q <= zpu_out3;
        end
    end

    assign sd.sd_lba = lba_q;

    // ---------------- request FSM ----------------
    sd_state_t state, state_n;
    logic      rd_q, rd_n, wr_q, wr_n, done_q, done_n;

`ifdef ZPU_SD_TIMEOUT_EN
    logic [23:0] cnt, cnt_n;
    logic        to_q, to_n;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state  <= IDLE;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b1;
`ifdef ZPU_SD_TIMEOUT_EN
            cnt    <= '0;
            to_q   <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            rd_q   <= rd_n;
            wr_q   <= wr_n;
            done_q <= done_n;
`ifdef ZPU_SD_TIMEOUT_EN
            cnt    <= cnt_n;
            to_q   <= to_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        rd_n    = rd_q;
        wr_n    = wr_q;
        done_n  = done_q;
`ifdef ZPU_SD_TIMEOUT_EN
        cnt_n   = cnt;
        to_n    = to_q;
`endif
        unique case (state)
            IDLE: begin
                // Read has priority when both requests rise together.
                if (blk_rd_rise | blk_wr_rise) begin
                    done_n  = 1'b0;
                    rd_n    = blk_rd_rise;
                    wr_n    = ~blk_rd_rise;
                    state_n = REQ;
`ifdef ZPU_SD_TIMEOUT_EN
                    cnt_n   = '0;
                    to_n    = 1'b0;
`endif
                end
            end
            REQ: begin
                if (sd.sd_ack) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    state_n = XFER;
                end
`ifdef ZPU_SD_TIMEOUT_EN
                else if (cnt == TIMEOUT_CYC - 24'd1) begin
                    rd_n    = 1'b0;
                    wr_n    = 1'b0;
                    done_n  = 1'b1;
                    to_n    = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 24'd1;
                end
`endif
            end
            XFER: begin
                if (ack_fall) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign sd.sd_rd = rd_q;
    assign sd.sd_wr = wr_q;

`ifdef ZPU_SD_TIMEOUT_EN
    assign sd_timeout = to_q;
`else
    assign sd_timeout = 1'b0;
`endif

    // ---------------- sector buffer ----------------
    logic [7:0] buf_q;
    logic       zpu_we;

    // hps_io owns the buffer for the whole transfer.
    assign zpu_we = dwr_ev & ~lba_sel & (state == IDLE);

    dpram #(BUF_AW, 8) sdbuf (
        .clk    (clk_sys),
        .addr_a (sd.sd_buff_addr),
        .we_a   (sd.sd_buff_wr),
        .d_a    (sd.sd_buff_dout),
        .q_a    (sd.sd_buff_din),
        .addr_b (addr),
        .we_b   (zpu_we),
        .d_b    (zpu_out3[7:0]),
        .q_b    (buf_q)
    );

    // ---------------- mount status ----------------
    logic [2:0]  fileno;
    logic [1:0]  filetype;
    logic        readonly;
    logic        mounted;
    logic [31:0] filesize;

    // mounted toggles on every mount so firmware can spot a remount.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fileno   <= '0;
            filetype <= '0;
            readonly <= 1'b1;
            mounted  <= |img_size[31:0];
            filesize <= '0;
        end else if (mnt_rise) begin
            fileno   <= '0;
            filetype <= ioctl_index[7:6];
            readonly <= 1'b1;
            mounted  <= ~mounted;
            filesize <= img_size[31:0];
        end
    end

    always_comb begin
        zpu_in2 = '0;
        zpu_in2[IN2_IO_DONE]        = done_q;
        zpu_in2[IN2_MOUNTED]        = mounted;
        zpu_in2[IN2_FILENO +: 3]    = fileno;
        zpu_in2[IN2_FILETYPE +: 2]  = filetype;
        zpu_in2[IN2_READONLY]       = readonly;
    end

    assign zpu_in3 = lba_sel ? filesize : {24'b0, buf_q};

    logic unused_bits;
    assign unused_bits = ^{zpu_out2[31:3], zpu_rd[15:3], zpu_rd[1:0],
                           zpu_wr[15:7], zpu_wr[4:0], img_size[63:32],
                           ioctl_index[5:0]};

endmodule

// File: doc/zpu_sd_bridge.md
Name: zpu_sd_bridge

Overview:
- Bridges the ZPU firmware register interface (OUT2/OUT3/RD/WR strobes) to the hps_io SD block interface for cartridge image loading.
- Contains the 512-byte sector buffer.
- Sequences block read and write requests.
- Latches the LBA.
- Reports mount status and image size back to the ZPU.
- Sits between atari5200top's ZPU ports and hps_io's sd_* ports in the emu top level.

Parameters:
- BUF_AW, 9, sector buffer address width (2^BUF_AW bytes).
- TIMEOUT_CYC, 24'd10_000_000, clk_sys cycles to wait for sd_ack. Used only with ZPU_SD_TIMEOUT_EN.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- zpu_out2  in  32  ZPU control: [0] lba_sel, [1] block_rd, [2] block_wr.
- zpu_out3  in  32  ZPU data or LBA value.
- zpu_rd  in  16  ZPU read strobes; [2] = data_rd.
- zpu_wr  in  16  ZPU write strobes; [5] = io_wr, [6] = data_wr.
- zpu_in2  out  8  status: {readonly, filetype[1:0], fileno[2:0], mounted, io_done}.
- zpu_in3  out  32  lba_sel ? filesize : {24'b0, buf_q}.
- sd_lba  out  32  block address to hps_io.
- sd_rd  out  1  block read request.
- sd_wr  out  1  block write request.
- sd_ack  in  1  hps_io transfer acknowledge.
- sd_buff_addr  in  BUF_AW  hps_io buffer address.
- sd_buff_dout  in  8  hps_io write data.
- sd_buff_din  out  8  buffer read data to hps_io.
- sd_buff_wr  in  1  hps_io buffer write enable.
- img_mounted  in  1  image mount pulse.
- img_size  in  64  image size in bytes.
- ioctl_index  in  8  menu index; [7:6] = file type.
- sd_timeout  out  1  sticky timeout flag. Tied 0 without ZPU_SD_TIMEOUT_EN.

Behaviour:
- Reset values:
  - sd_rd = 0, sd_wr = 0, sd_lba = 0, buffer address = 0, io_done = 1, state = IDLE, sd_timeout = 0.
  - fileno = 0, filetype = 0, readonly = 1, filesize = 0.
  - mounted = |img_size[31:0], sampled during reset.
- Reset mid-transfer: requests drop in the same cycle and the state returns to IDLE. A late sd_ack is ignored.
- data_wr edge detect:
  - Two-stage delay (d1, d2). The event fires when d1 & ~d2, i.e. 2 cycles after the strobe rises.
  - If lba_sel = 1: sd_lba <= zpu_out3.
  - Else: write zpu_out3[7:0] to the buffer at the current address; the address increments on the following cycle.
- data_rd: falling edge (registered previous value & ~current) increments the address. buf_q is the registered port-B read; latency is 1 cycle after the address changes.
- io_wr high sets the address to 0. This has priority over any same-cycle increment.
- Address wraps modulo 2^BUF_AW (511 -> 0).
- Request FSM:
  - IDLE:
    - Rising edge of block_rd: io_done <= 0, sd_rd <= 1, go to REQ.
    - Rising edge of block_wr: io_done <= 0, sd_wr <= 1, go to REQ.
    - Both rising in the same cycle: the read wins.
    - Edges seen outside IDLE are ignored.
  - REQ: sd_ack = 1 -> sd_rd <= 0, sd_wr <= 0, go to XFER.
  - XFER: falling edge of sd_ack -> io_done <= 1, go to IDLE.
- ZPU buffer writes are dropped while state != IDLE. Port A (hps_io) has sole write access during a transfer.
- Mount: rising edge of img_mounted (outside reset):
  - fileno <= 0, filetype <= ioctl_index[7:6], readonly <= 1.
  - mounted <= ~mounted (toggle, so firmware detects each new mount).
  - filesize <= img_size[31:0].
- zpu_in3 mux is combinational on lba_sel.

Optional Feature:
- Macro ZPU_SD_TIMEOUT_EN.
- When defined:
  - A 24-bit counter clears on entry to REQ and increments each cycle in REQ.
  - When it reaches TIMEOUT_CYC: sd_rd/sd_wr <= 0, io_done <= 1, sd_timeout <= 1, go to IDLE.
  - sd_timeout clears on the next accepted block request.
- When undefined:
  - REQ waits indefinitely.
  - sd_timeout is constant 0 and no counter is synthesised.

Decomposition:
- Package zpu_sd_pkg:
  - Enum sd_state_t {IDLE, REQ, XFER}.
  - Bit-index localparams for OUT2, RD and WR strobe positions.
  - IN2 field positions.
  - Default TIMEOUT_CYC.
- One sub-module: the existing dpram #(BUF_AW,8) instance as sdbuf.
  - Port A: hps_io.
  - Port B: ZPU.

Test Plan:
- Reset with img_size = 4096 -> zpu_in2 = 8'b1000_0011 (mounted = 1, io_done = 1, readonly = 1); sd_rd = sd_wr = 0.
- LBA latch: lba_sel = 1, zpu_out3 = 32'h0000_0123, pulse data_wr -> sd_lba = 32'h123 three cycles after the strobe rises; zpu_in3 = filesize.
- Block read:
  - Stimulus: io_wr pulse, then rise block_rd; model asserts sd_ack 5 cycles later, writes bytes 0..511 = addr^8'hA5, then drops sd_ack.
  - Response: io_done goes 0 and sd_rd goes 1 on the edge cycle; sd_rd drops the cycle after sd_ack; io_done = 1 the cycle after sd_ack falls; 512 data_rd pulses return A5, A4, ... in order; after the 512th the address wraps to 0.
- Block write: 512 ZPU data_wr bytes 0..255 twice, then rise block_wr -> sd_wr = 1; hps_io reads sd_buff_din matching the written bytes; a ZPU data_wr during XFER leaves the buffer unchanged.
- Mount toggle: two img_mounted pulses with ioctl_index = 8'h40 -> mounted toggles 1 -> 0 -> 1; filetype = 2'b01; filesize updates to the new img_size.
- Timeout (macro defined, TIMEOUT_CYC = 100): block_rd with no sd_ack -> after 100 cycles sd_rd = 0, io_done = 1, sd_timeout = 1; next block_rd clears sd_timeout.
